// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and types for the register file slice
//
// Purpose: default geometry of the register file and the matching address and
// data types used by the decoder/writeback side at the default width.
// Ports: none (package).
package regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_NREG   = 1 << DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read, write, reservation and clear bundle of the register file
//
// Purpose: groups every non-clock/reset signal of regfile_sb.
// Ports (master = decoder/writeback side, slave = register file):
//   rd_addr_a/b  -> read addresses        rd_data_a/b <- read data
//   rd_busy_a/b  <- addressed reg busy    clr         -> synchronous clear
//   wr_en/wr_addr/wr_data -> write port
//   rsv_en/rsv_addr -> reservation request, rsv_ok <- request accepted
//   busy_vec     <- busy bit per register
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  localparam int NREG = 1 << ADDR_W;

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ok;
  logic [NREG-1:0]   busy_vec;
  logic              clr;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rsv_ok, busy_vec
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rsv_ok, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy bits, reservation accept and busy read bypass
//
// Purpose: holds one busy bit per register. A write clears the bit, an accepted
// reservation sets it (reservation wins on a same-address collision), clr
// zeroes everything.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   clr               synchronous clear of all busy bits
//   wr_en, wr_addr    effective write (already masked for reset / zero register)
//   rsv_en, rsv_addr  reservation request
//   rd_addr_a/b       read addresses for the busy lookup
//   rsv_ok            reservation accepted this cycle
//   rd_busy_a/b       busy status seen by each read port
//   busy_vec          registered busy bits
module regfile_scoreboard #(
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic                   rsv_ok,
  output logic                   rd_busy_a,
  output logic                   rd_busy_b,
  output logic [(1<<ADDR_W)-1:0] busy_vec
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            rsv_take;

  // busy_q[0] is held at 0 with a zero register, so a request to r0 is always
  // accepted but must never set state.
  always_comb begin
    rsv_ok   = rsv_en & ~busy_q[rsv_addr];
    rsv_take = rsv_ok && !(ZERO_REG != 0 && rsv_addr == '0);
  end

  always_comb begin
    busy_d = busy_q;
    if (clr) begin
      busy_d = '0;
    end else begin
      if (wr_en)    busy_d[wr_addr]  = 1'b0;
      if (rsv_take) busy_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  // A write to the read address shows the register as free in the write cycle,
  // unless a reservation to that address is accepted in the same cycle; then the
  // pre-edge value is reported (always 0, since rsv_ok needs a free register).
  always_comb begin
    rd_busy_a = busy_q[rd_addr_a];
    if (wr_en && wr_addr == rd_addr_a)
      rd_busy_a = (rsv_ok && rsv_addr == rd_addr_a) ? busy_q[rd_addr_a] : 1'b0;
  end

  always_comb begin
    rd_busy_b = busy_q[rd_addr_b];
    if (wr_en && wr_addr == rd_addr_b)
      rd_busy_b = (rsv_ok && rsv_addr == rd_addr_b) ? busy_q[rd_addr_b] : 1'b0;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write-first bypass and busy scoreboard
//
// Purpose: NREG x DATA_W data array, two combinational read ports with bypass
// from the write port, optional hard-wired zero register, synchronous clear and
// per-register reservation tracking (regfile_scoreboard).
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   asynchronous active-low reset of data and busy bits
//   bus   regfile_sb_if.slave: read ports, write port, reservation, clr, busy_vec
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic              wr_act;

  // Writes are dropped while reset is held (including their bypass, so reads
  // stay at 0) and when they target a hard-wired zero register.
  assign wr_act = rst && bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_act) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Bypass is independent of clr: the value being written is still what the
  // reader sees in that cycle.
  always_comb begin
    bus.rd_data_a = mem[bus.rd_addr_a];
    if (ZERO_REG != 0 && bus.rd_addr_a == '0)    bus.rd_data_a = '0;
    else if (wr_act && bus.wr_addr == bus.rd_addr_a) bus.rd_data_a = bus.wr_data;
  end

  always_comb begin
    bus.rd_data_b = mem[bus.rd_addr_b];
    if (ZERO_REG != 0 && bus.rd_addr_b == '0)    bus.rd_data_b = '0;
    else if (wr_act && bus.wr_addr == bus.rd_addr_b) bus.rd_data_b = bus.wr_data;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.clr),
    .wr_en     (wr_act),
    .wr_addr   (bus.wr_addr),
    .rsv_en    (bus.rsv_en),
    .rsv_addr  (bus.rsv_addr),
    .rd_addr_a (bus.rd_addr_a),
    .rd_addr_b (bus.rd_addr_b),
    .rsv_ok    (bus.rsv_ok),
    .rd_busy_a (bus.rd_busy_a),
    .rd_busy_b (bus.rd_busy_b),
    .busy_vec  (bus.busy_vec)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_z = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(8),  .ADDR_W(2)) bus_a ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_z ();

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_dut_z (
    .clk (clk),
    .rst (rst_z),
    .bus (bus_z.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.wr_en = 1'b0; bus_a.rsv_en = 1'b0; bus_a.clr = 1'b0;
    bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.rsv_addr = '0;
  endtask

  task automatic idle_z();
    bus_z.wr_en = 1'b0; bus_z.rsv_en = 1'b0; bus_z.clr = 1'b0;
    bus_z.wr_addr = '0; bus_z.wr_data = '0; bus_z.rsv_addr = '0;
  endtask

  reg_addr_t ra;
  reg_data_t rd;

  initial begin
    idle_a();
    idle_z();
    bus_a.rd_addr_a = '0; bus_a.rd_addr_b = '0;
    bus_z.rd_addr_a = '0; bus_z.rd_addr_b = '0;

    // Reset held with random activity on the ports.
    for (int i = 0; i < 3; i++) begin
      ra = reg_addr_t'($urandom);
      rd = reg_data_t'($urandom) | 8'h01;
      bus_a.rd_addr_a = ra;  bus_a.wr_addr = ra;  bus_a.wr_data = rd;
      bus_a.rd_addr_b = reg_addr_t'($urandom);
      bus_a.wr_en = 1'b1; bus_a.rsv_en = 1'b1; bus_a.rsv_addr = ra;
      bus_a.clr = 1'($urandom);
      bus_z.wr_en = 1'b1; bus_z.wr_addr = 3'd5; bus_z.wr_data = 16'hCAFE;
      bus_z.rd_addr_a = 3'd5; bus_z.rsv_en = 1'b1; bus_z.rsv_addr = 3'd5;
      #2;
      chk("rst_rd_data_a", 32'(bus_a.rd_data_a), 32'h0);
      chk("rst_rd_data_b", 32'(bus_a.rd_data_b), 32'h0);
      chk("rst_busy_vec",  32'(bus_a.busy_vec),  32'h0);
      chk("rst_rd_busy_a", 32'(bus_a.rd_busy_a), 32'h0);
      chk("rst_rsv_ok",    32'(bus_a.rsv_ok),    32'h1);
      chk("rst_z_rd_data", 32'(bus_z.rd_data_a), 32'h0);
      tick();
    end
    idle_a();
    idle_z();
    rst_a = 1'b1;
    rst_z = 1'b1;
    #2;
    bus_a.rd_addr_a = 2'd0; bus_a.rd_addr_b = 2'd3;
    #1;
    chk("post_rst_r0", 32'(bus_a.rd_data_a), 32'h0);
    chk("post_rst_r3", 32'(bus_a.rd_data_b), 32'h0);
    tick();

    // Write r2 = A5: bypass now, array next cycle.
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 2'd2; bus_a.wr_data = 8'hA5;
    bus_a.rd_addr_a = 2'd2; bus_a.rd_addr_b = 2'd1;
    #2;
    chk("wr_r2_bypass", 32'(bus_a.rd_data_a), 32'hA5);
    chk("wr_r2_other",  32'(bus_a.rd_data_b), 32'h0);
    tick();
    idle_a();
    #2;
    chk("wr_r2_array", 32'(bus_a.rd_data_a), 32'hA5);
    tick();

    // Reserve r1, then a second reserve is refused.
    bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 2'd1; bus_a.rd_addr_a = 2'd1;
    #2;
    chk("rsv_r1_ok",     32'(bus_a.rsv_ok),    32'h1);
    chk("rsv_r1_pre",    32'(bus_a.busy_vec),  32'h0);
    tick();
    #2;
    chk("rsv_r1_again",  32'(bus_a.rsv_ok),    32'h0);
    chk("rsv_r1_vec",    32'(bus_a.busy_vec),  32'h2);
    chk("rsv_r1_rdbusy", 32'(bus_a.rd_busy_a), 32'h1);
    tick();
    #2;
    chk("rsv_r1_hold",   32'(bus_a.busy_vec),  32'h2);
    bus_a.rsv_en = 1'b0;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 2'd1; bus_a.wr_data = 8'h3C;
    #1;
    chk("wr_r1_bypass",  32'(bus_a.rd_data_a), 32'h3C);
    chk("wr_r1_rdbusy",  32'(bus_a.rd_busy_a), 32'h0);
    chk("wr_r1_vec_pre", 32'(bus_a.busy_vec),  32'h2);
    tick();
    idle_a();
    #2;
    chk("wr_r1_vec",     32'(bus_a.busy_vec),  32'h0);
    chk("wr_r1_array",   32'(bus_a.rd_data_a), 32'h3C);
    tick();

    // Same-cycle write and reservation of r3: reservation wins.
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 2'd3; bus_a.wr_data = 8'h11;
    bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 2'd3; bus_a.rd_addr_a = 2'd3;
    #2;
    chk("wrrsv_r3_ok",     32'(bus_a.rsv_ok),    32'h1);
    chk("wrrsv_r3_bypass", 32'(bus_a.rd_data_a), 32'h11);
    chk("wrrsv_r3_rdbusy", 32'(bus_a.rd_busy_a), 32'h0);
    tick();
    idle_a();
    #2;
    chk("wrrsv_r3_vec",    32'(bus_a.busy_vec),  32'h8);
    chk("wrrsv_r3_data",   32'(bus_a.rd_data_a), 32'h11);
    chk("wrrsv_r3_rdbusy2",32'(bus_a.rd_busy_a), 32'h1);
    tick();

    // r3 busy: write + reserve again -> refused, write clears busy.
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 2'd3; bus_a.wr_data = 8'h22;
    bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 2'd3;
    #2;
    chk("busy_r3_rsv_ok", 32'(bus_a.rsv_ok), 32'h0);
    tick();
    idle_a();
    #2;
    chk("busy_r3_vec",  32'(bus_a.busy_vec),  32'h0);
    chk("busy_r3_data", 32'(bus_a.rd_data_a), 32'h22);
    tick();

    // Clear overrides a write to r0 and a reservation of r2.
    bus_a.clr = 1'b1;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 2'd0; bus_a.wr_data = 8'hFF;
    bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 2'd2;
    bus_a.rd_addr_a = 2'd0; bus_a.rd_addr_b = 2'd2;
    #2;
    chk("clr_bypass_r0", 32'(bus_a.rd_data_a), 32'hFF);
    tick();
    idle_a();
    #2;
    chk("clr_r0",  32'(bus_a.rd_data_a), 32'h0);
    chk("clr_r2",  32'(bus_a.rd_data_b), 32'h0);
    chk("clr_vec", 32'(bus_a.busy_vec),  32'h0);
    bus_a.rd_addr_a = 2'd1; bus_a.rd_addr_b = 2'd3;
    #1;
    chk("clr_r1",  32'(bus_a.rd_data_a), 32'h0);
    chk("clr_r3",  32'(bus_a.rd_data_b), 32'h0);
    tick();

    // Zero-register instance, 16-bit data, 8 registers.
    bus_z.wr_en = 1'b1; bus_z.wr_addr = 3'd0; bus_z.wr_data = 16'hBEEF;
    bus_z.rsv_en = 1'b1; bus_z.rsv_addr = 3'd0;
    bus_z.rd_addr_a = 3'd0; bus_z.rd_addr_b = 3'd7;
    #2;
    chk("z_r0_nobypass", 32'(bus_z.rd_data_a), 32'h0);
    chk("z_r0_rsv_ok",   32'(bus_z.rsv_ok),    32'h1);
    tick();
    idle_z();
    #2;
    chk("z_r0_data",     32'(bus_z.rd_data_a), 32'h0);
    chk("z_r0_busy",     32'(bus_z.rd_busy_a), 32'h0);
    chk("z_r0_vec",      32'(bus_z.busy_vec),  32'h0);
    bus_z.wr_en = 1'b1; bus_z.wr_addr = 3'd7; bus_z.wr_data = 16'hBEEF;
    #1;
    chk("z_r7_bypass",   32'(bus_z.rd_data_b), 32'hBEEF);
    tick();
    idle_z();
    #2;
    chk("z_r7_array",    32'(bus_z.rd_data_b), 32'hBEEF);
    bus_z.wr_en = 1'b1; bus_z.wr_addr = 3'd5; bus_z.wr_data = 16'h1234;
    tick();
    idle_z();
    bus_z.rsv_en = 1'b1; bus_z.rsv_addr = 3'd5;
    tick();
    idle_z();
    bus_z.rd_addr_a = 3'd5;
    #2;
    chk("z_r5_data", 32'(bus_z.rd_data_a), 32'h1234);
    chk("z_r5_busy", 32'(bus_z.rd_busy_a), 32'h1);
    chk("z_r5_vec",  32'(bus_z.busy_vec),  32'h20);

    // Asynchronous reset between edges clears immediately.
    rst_z = 1'b0;
    #1;
    chk("z_async_data", 32'(bus_z.rd_data_a), 32'h0);
    chk("z_async_busy", 32'(bus_z.rd_busy_a), 32'h0);
    chk("z_async_vec",  32'(bus_z.busy_vec),  32'h0);
    chk("z_async_r7",   32'(bus_z.rd_data_b), 32'h0);
    tick();
    #2;
    rst_z = 1'b1;
    #1;
    chk("z_after_rst_r7", 32'(bus_z.rd_data_b), 32'h0);
    tick();
    bus_z.wr_en = 1'b1; bus_z.wr_addr = 3'd5; bus_z.wr_data = 16'h5A5A;
    tick();
    idle_z();
    #2;
    chk("z_after_rst_wr", 32'(bus_z.rd_data_a), 32'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated busy scoreboard, the successor to the fixed 4×8-bit CPU register bank. It provides two combinational read ports with write-first bypass, one write port, a per-register reservation (busy) bit for multi-cycle producers, an optional hard-wired zero register, and a synchronous clear. It sits between the instruction decoder (read addresses, reservations) and the writeback stage (write port).

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 2, address width; NREG = 2**ADDR_W registers
- ZERO_REG, 0, if 1, register 0 always reads 0 and ignores writes and reservations
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all data and busy bits
- clr  in  1  synchronous clear of all data and busy bits
- rd_addr_a, rd_addr_b  in  ADDR_W  read port addresses
- rd_data_a, rd_data_b  out  DATA_W  read data (combinational)
- rd_busy_a, rd_busy_b  out  1  addressed register is reserved (combinational)
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reservation request
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- busy_vec  out  NREG  current busy bits, bit i = register i

## Operation
- Storage: NREG × DATA_W data array plus NREG busy bits.
- Write: wr_en=1 at rising edge → data[wr_addr] ← wr_data, busy[wr_addr] ← 0. Writing a non-busy register is legal.
- Reservation: rsv_ok = rsv_en & ~busy[rsv_addr]; on edge with rsv_ok=1, busy[rsv_addr] ← 1. Reserving an already-busy register: rsv_ok=0, no state change.
- Same-cycle write and reservation to one address: data updated, busy ends at 1 (reservation wins; new producer owns it). rsv_ok evaluated against pre-edge busy only.
- Read bypass: if wr_en & wr_addr==rd_addr_x, rd_data_x = wr_data and rd_busy_x = 0 (unless rsv_ok to same address, then rd_busy_x = busy pre-edge value); otherwise rd_data_x = data[rd_addr_x], rd_busy_x = busy[rd_addr_x].
- ZERO_REG=1: reads of address 0 return 0, rd_busy=0; writes to 0 ignored, no bypass; rsv_en to 0 gives rsv_ok=1 with no state change; busy_vec[0] always 0.
- clr=1 at edge: all data and busy bits ← 0; overrides wr_en and rsv_en that cycle. Bypass still applies combinationally during that cycle.
- rst low: immediate, asynchronous zero of data and busy bits; wr/rsv/clr ignored while low.

## Timing
- Reset values: rd_data_a/b = 0, rd_busy_a/b = 0, busy_vec = 0, rsv_ok = rsv_en.
- Read latency 0 cycles (combinational from addresses and write port).
- Write visible through bypass in the same cycle, from the array from the following cycle.
- Busy set visible the cycle after rsv_ok; cleared the cycle after the write, bypass-visible in the write cycle.
- Reset deassertion mid-operation: first rising edge after rst goes high performs normal updates; no partial writes from the reset cycle.
- No handshake stalls inside the block; caller stalls on rd_busy_x or rsv_ok=0.

## Structure
- Shared package regfile_pkg: default DATA_W/ADDR_W constants, reg_addr_t and reg_data_t typedefs.
- One sub-module natural: regfile_scoreboard (busy vector, rsv_ok, set/clear/priority logic); data array and bypass muxes in top level.

## Test plan
- Reset: rst low with random inputs → all rd_data 0, busy_vec 0; release, write 8'hA5 to r2 → r2 reads 8'hA5 next cycle, 8'hA5 via bypass in write cycle.
- Reserve r1 (rsv_ok=1) → busy_vec=4'b0010, rd_busy on r1=1; second reserve of r1 → rsv_ok=0; write 8'h3C to r1 → bypass 8'h3C, busy 0, busy_vec=0 next cycle.
- Same-cycle wr r3=8'h11 and rsv r3 (not busy) → r3=8'h11, busy_vec[3]=1 next cycle.
- clr with simultaneous wr r0=8'hFF and rsv r2 → all data 0, busy_vec 0 next cycle.
- ZERO_REG=1, DATA_W=16, ADDR_W=3: write 16'hBEEF to r0 → r0 reads 0, rsv r0 → rsv_ok=1, busy_vec=0; r7 write/read 16'hBEEF works.
- rst asserted mid-cycle between edges with r5 busy and data 16'h1234 → outputs zero immediately, before next edge.
